// File: rtl/uart_xmit.sv
// uart_xmit: 8N1 UART transmitter with a one-deep holding buffer.
// Each bit cell is BIT_CELL sys_clk cycles; the line idles high.
module uart_xmit #(
    parameter int WORD_LEN = 8,
    parameter int BIT_CELL = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rstH,
    input  logic                xmitH,
    input  logic [WORD_LEN-1:0] xmit_dataH,
    output logic                xmit_readyH,
    output logic                xmit_busyH,
    output logic                xmit_doneH,
    output logic                uart_xmitH
);

    localparam int CNT_W  = (BIT_CELL > 1) ? $clog2(BIT_CELL) : 1;
    localparam int BITS_W = $clog2(WORD_LEN) + 1;

    localparam logic [CNT_W-1:0] CELL_LAST =
        CNT_W'(BIT_CELL - 1);
    localparam logic [CNT_W-1:0] CELL_PRE =
        CNT_W'((BIT_CELL > 1) ? BIT_CELL - 2 : 0);
    localparam logic [BITS_W-1:0] WORD_LAST =
        BITS_W'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [WORD_LEN-1:0] holdReg;
    logic                holdFull;
    logic [WORD_LEN-1:0] shifter;
    logic [WORD_LEN-1:0] shiftNext;
    logic [CNT_W-1:0]    cellCnt;
    logic [BITS_W-1:0]   bitCnt;
    logic                cellLast;
    logic                accept;
    logic                load;
    logic                holdNext;

    assign cellLast  = (cellCnt == CELL_LAST);
    assign shiftNext = shifter >> 1;
    assign accept    = xmitH & xmit_readyH;
    // The buffer drains into the shifter from IDLE, or
    // straight out of the final stop-bit cycle for gapless frames.
    assign load      = holdFull &
                       ((state == IDLE) |
                        ((state == STOP) & cellLast));
    assign holdNext  = accept | (holdFull & ~load);

    // Holding buffer, frame sequencer and all registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            state       <= IDLE;
            holdReg     <= '0;
            holdFull    <= 1'b0;
            shifter     <= '0;
            cellCnt     <= '0;
            bitCnt      <= '0;
            uart_xmitH  <= 1'b1;
            xmit_readyH <= 1'b1;
            xmit_busyH  <= 1'b0;
            xmit_doneH  <= 1'b0;
        end else begin
            xmit_doneH  <= 1'b0;
            holdFull    <= holdNext;
            xmit_readyH <= ~holdNext;
            if (accept) begin
                holdReg <= xmit_dataH;
            end
            case (state)
                IDLE: begin
                    uart_xmitH <= 1'b1;
                    xmit_busyH <= 1'b0;
                    cellCnt    <= '0;
                    if (holdFull) begin
                        state      <= START;
                        shifter    <= holdReg;
                        bitCnt     <= '0;
                        uart_xmitH <= 1'b0;
                        xmit_busyH <= 1'b1;
                    end
                end
                START: begin
                    if (cellLast) begin
                        state      <= DATA;
                        cellCnt    <= '0;
                        bitCnt     <= '0;
                        uart_xmitH <= shifter[0];
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cellLast) begin
                        cellCnt <= '0;
                        shifter <= shiftNext;
                        bitCnt  <= bitCnt + BITS_W'(1);
                        if (bitCnt == WORD_LAST) begin
                            state      <= STOP;
                            uart_xmitH <= 1'b1;
                            xmit_doneH <= (BIT_CELL == 1);
                        end else begin
                            uart_xmitH <= shiftNext[0];
                        end
                    end else begin
                        cellCnt <= cellCnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cellLast) begin
                        cellCnt <= '0;
                        if (holdFull) begin
                            state      <= START;
                            shifter    <= holdReg;
                            bitCnt     <= '0;
                            uart_xmitH <= 1'b0;
                            xmit_busyH <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            uart_xmitH <= 1'b1;
                            xmit_busyH <= 1'b0;
                        end
                    end else begin
                        cellCnt    <= cellCnt + CNT_W'(1);
                        xmit_doneH <= (cellCnt == CELL_PRE);
                    end
                end
                default: begin
                    state      <= IDLE;
                    cellCnt    <= '0;
                    uart_xmitH <= 1'b1;
                    xmit_busyH <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xmit.sv
// tb_uart_xmit: directed and random stimulus for uart_xmit,
// checked each cycle against a frame-level reference model.
module tb_uart_xmit;

    localparam int CELL  = 16;
    localparam int FRAME = 10 * CELL;

    logic       sys_clk    = 1'b0;
    logic       sys_rstH   = 1'b1;
    logic       xmitH      = 1'b0;
    logic [7:0] xmit_dataH = 8'h00;
    logic       xmit_readyH;
    logic       xmit_busyH;
    logic       xmit_doneH;
    logic       uart_xmitH;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: edge count, active frame, pending byte.
    int         cyc      = 0;
    int         curStart = -1000;
    logic [7:0] curByte  = 8'h00;
    bit         pend     = 1'b0;
    logic [7:0] pendByte = 8'h00;
    bit         accepted = 1'b0;

    uart_xmit #(
        .WORD_LEN(8),
        .BIT_CELL(CELL)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rstH   (sys_rstH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_readyH(xmit_readyH),
        .xmit_busyH (xmit_busyH),
        .xmit_doneH (xmit_doneH),
        .uart_xmitH (uart_xmitH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic modelReset();
        pend     = 1'b0;
        curStart = -1000;
    endtask

    // One clock edge of the model, using the inputs seen at the edge.
    task automatic modelEdge();
        bit pendBefore;
        bit acc;
        bit xfer;
        accepted = 1'b0;
        if (sys_rstH) begin
            modelReset();
        end else begin
            pendBefore = pend;
            acc  = xmitH && !pendBefore;
            xfer = pendBefore && (cyc >= curStart + FRAME);
            if (xfer) begin
                curStart = cyc;
                curByte  = pendByte;
            end
            if (acc) begin
                pendByte = xmit_dataH;
                accepted = 1'b1;
            end
            pend = acc ? 1'b1 : (xfer ? 1'b0 : pendBefore);
        end
    endtask

    task automatic check(input string tag);
        bit   act;
        int   k;
        logic eLine;
        logic eBusy;
        logic eDone;
        logic eReady;
        act = (cyc >= curStart) && (cyc < curStart + FRAME);
        k   = (cyc - curStart) / CELL;
        if (!act)       eLine = 1'b1;
        else if (k == 0) eLine = 1'b0;
        else if (k <= 8) eLine = curByte[k-1];
        else             eLine = 1'b1;
        eBusy  = act;
        eDone  = act && (cyc == curStart + FRAME - 1);
        eReady = !pend;
        vectors++;
        assert (uart_xmitH === eLine) else begin
            miscompares++;
            $error("FAIL %s line cyc=%0d got=%b exp=%b",
                   tag, cyc, uart_xmitH, eLine);
        end
        assert (xmit_busyH === eBusy) else begin
            miscompares++;
            $error("FAIL %s busy cyc=%0d got=%b exp=%b",
                   tag, cyc, xmit_busyH, eBusy);
        end
        assert (xmit_doneH === eDone) else begin
            miscompares++;
            $error("FAIL %s done cyc=%0d got=%b exp=%b",
                   tag, cyc, xmit_doneH, eDone);
        end
        assert (xmit_readyH === eReady) else begin
            miscompares++;
            $error("FAIL %s ready cyc=%0d got=%b exp=%b",
                   tag, cyc, xmit_readyH, eReady);
        end
    endtask

    task automatic step(input logic x, input logic [7:0] d,
                        input string tag);
        xmitH      = x;
        xmit_dataH = d;
        @(posedge sys_clk);
        cyc++;
        modelEdge();
        #1;
        check(tag);
    endtask

    // Hold the strobe with filler data until ready, then write d.
    task automatic writeWhenReady(input logic [7:0] d,
                                  input logic [7:0] filler,
                                  input string tag);
        int n;
        n = 0;
        while (pend && n < 400) begin
            step(1'b1, filler, tag);
            n++;
        end
        vectors++;
        assert (!pend) else begin
            miscompares++;
            $error("FAIL %s ready-timeout got=%b exp=%b",
                   tag, xmit_readyH, 1'b1);
        end
        step(1'b1, d, tag);
        xmitH = 1'b0;
    endtask

    initial begin
        int n0;

        repeat (3) step(1'b0, 8'h00, "reset");
        sys_rstH = 1'b0;
        repeat (50) step(1'b0, 8'h00, "idle");

        step(1'b1, 8'hA5, "a5wr");
        repeat (170) step(1'b0, 8'h00, "a5");

        step(1'b1, 8'h00, "b2b00");
        writeWhenReady(8'hFF, 8'hFF, "b2bff");
        repeat (330) step(1'b0, 8'h00, "b2b");

        step(1'b1, 8'h11, "ovf11");
        writeWhenReady(8'h22, 8'h44, "ovf22");
        writeWhenReady(8'h33, 8'h44, "ovf33");
        repeat (500) step(1'b0, 8'h00, "ovf");

        n0 = cyc + 1;
        step(1'b1, 8'h0F, "mid0f");
        repeat (5) step(1'b0, 8'h00, "mid");
        step(1'b1, 8'hC3, "midc3");
        while (cyc < n0 + 70) step(1'b0, 8'h00, "mid");
        #2;
        sys_rstH = 1'b1;
        modelReset();
        #1;
        check("rstasync");
        repeat (3) step(1'b0, 8'h00, "rsthold");
        sys_rstH = 1'b0;
        repeat (200) step(1'b0, 8'h00, "postrst");
        step(1'b1, 8'h5A, "5awr");
        repeat (170) step(1'b0, 8'h00, "5a");

        repeat (1000) step(1'b1, 8'h3C, "held3c");
        repeat (330) step(1'b0, 8'h00, "held");

        repeat (3000) step(($urandom_range(0, 99) < 4),
                           8'($urandom), "rand");
        repeat (1500) step(($urandom_range(0, 9) < 8),
                           8'($urandom), "burst");
        repeat (330) step(1'b0, 8'h00, "drain");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
